rr_result_arbiter: RTL and testbench

- Round-robin arbiter and write sequencer between the NUM_PROC Mandelbrot engines and the VGA dual-port frame RAM.
- Grants one requesting engine at a time. While granted, that engine drives its 27-bit result word onto the shared tri-state bus.
- Captures the word and converts {x,y} into a linear RAM address (x + y*H_RES). Issues a single-cycle RAM write.
- Counts written pixels and flags frame completion.

---
 rtl/rr_result_arbiter.sv | 134 +++++++++++++
 tb/tb_rr_result_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_result_arbiter.sv
// Round-robin arbiter that grants Mandelbrot engines the shared result bus and turns each {x,y,iter} word into a frame RAM write.
// Latency: grant 1 cycle after request, write strobe 4 cycles after request; requesters are held off (never dropped) while the FSM is busy.
module rr_result_arbiter #(
  parameter int NUM_PROC   = 12,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk_iCLK,
  input  logic                  reset,
  input  logic [NUM_PROC-1:0]   engine_req,
  output logic [NUM_PROC-1:0]   req_ack,
  input  logic [26:0]           engine_word,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_data,
  output logic                  ram_wr_en,
  output logic                  frame_done,
  output logic                  coord_err,
  output logic                  busy
);

  localparam int IDX_W     = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam int FRAME_PIX = H_RES * V_RES;
  localparam int CNT_W     = $clog2(FRAME_PIX + 1);

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] iter;
  } word_t;

  typedef enum logic [1:0] {IDLE, GRANT, CAPTURE, WAIT_REL} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      ptr, gnt_idx, sel_idx, cand_idx;
  logic                  sel_vld;
  int                    cand;
  word_t                 cap_word;
  logic                  cap_vld;
  logic [ADDR_WIDTH-1:0] x_ext, y_ext, lin_addr;
  logic                  in_range, wr_nxt, last_pix;
  logic [CNT_W-1:0]      pix_cnt;

  // First requester at or above the pointer, wrapping past the top engine.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_PROC) cand = cand - NUM_PROC;
      cand_idx = IDX_W'(cand);
      if (!sel_vld && engine_req[cand_idx]) begin
        sel_vld = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk_iCLK or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_vld) gnt_idx <= sel_idx;
      if (state == CAPTURE)
        ptr <= (gnt_idx == IDX_W'(NUM_PROC - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    req_ack   = '0;
    case (state)
      IDLE:     if (sel_vld) state_nxt = GRANT;
      GRANT: begin
        req_ack[gnt_idx] = 1'b1;
        state_nxt = engine_req[gnt_idx] ? CAPTURE : IDLE;
      end
      CAPTURE: begin
        req_ack[gnt_idx] = 1'b1;
        state_nxt = WAIT_REL;
      end
      WAIT_REL: if (!engine_req[gnt_idx]) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Address and range check are computed side by side from the captured word.
  assign x_ext = ADDR_WIDTH'(cap_word.x);
  assign y_ext = ADDR_WIDTH'(cap_word.y);

  generate
    if (H_RES == 640) begin : g_shift
      assign lin_addr = (y_ext << 9) + (y_ext << 7) + x_ext;
    end else begin : g_mul
      assign lin_addr = y_ext * ADDR_WIDTH'(H_RES) + x_ext;
    end
  endgenerate

  assign in_range = (int'(cap_word.x) < H_RES) && (int'(cap_word.y) < V_RES);
  assign wr_nxt   = cap_vld && in_range;
  assign last_pix = (pix_cnt == CNT_W'(FRAME_PIX - 1));

  always_ff @(posedge clk_iCLK or posedge reset) begin
    if (reset) begin
      cap_vld    <= 1'b0;
      cap_word   <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_wr_en  <= 1'b0;
      frame_done <= 1'b0;
      coord_err  <= 1'b0;
      pix_cnt    <= '0;
    end else begin
      cap_vld    <= (state == CAPTURE);
      if (state == CAPTURE) cap_word <= word_t'(engine_word);
      ram_wr_en  <= wr_nxt;
      frame_done <= wr_nxt && last_pix;
      if (wr_nxt) begin
        ram_addr <= lin_addr;
        ram_data <= cap_word.iter;
        pix_cnt  <= last_pix ? '0 : pix_cnt + CNT_W'(1);
      end
      if (cap_vld && !in_range) coord_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_result_arbiter.sv
// Bench for rr_result_arbiter: randomized engines, a round-robin reference model and a write scoreboard,
// plus a small-frame instance to reach frame completion quickly.
module tb_rr_result_arbiter;

  localparam int NP = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NP-1:0] engine_req = '0;
  logic [NP-1:0] req_ack;
  logic [26:0]   engine_word;
  logic [18:0]   ram_addr;
  logic [7:0]    ram_data;
  logic          ram_wr_en, frame_done, coord_err, busy;

  logic [1:0]    s_req = '0;
  logic [1:0]    s_ack;
  logic [26:0]   s_word = '0;
  logic [5:0]    s_addr;
  logic [7:0]    s_data;
  logic          s_wr_en, s_frame_done, s_coord_err, s_busy;

  typedef struct { int addr; int data; int due; } exp_t;
  exp_t exp_q[$];
  exp_t s_q[$];

  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic [26:0] eng_word [NP];
  logic [26:0] garbage = '0;
  bit          exp_err = 1'b0;

  int            m_ptr = 0, m_run = 0, m_gcur = 0, m_g = 0;
  bit            m_bprev = 1'b0, m_reqg = 1'b0;
  logic [NP-1:0] m_rprev = '0;
  int            s_writes = 0, s_frames = 0;

  rr_result_arbiter dut (
    .clk_iCLK(clk), .reset(reset), .engine_req(engine_req), .req_ack(req_ack),
    .engine_word(engine_word), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wr_en(ram_wr_en), .frame_done(frame_done), .coord_err(coord_err), .busy(busy)
  );

  rr_result_arbiter #(.NUM_PROC(2), .H_RES(8), .V_RES(4), .ADDR_WIDTH(6)) dut_small (
    .clk_iCLK(clk), .reset(reset), .engine_req(s_req), .req_ack(s_ack),
    .engine_word(s_word), .ram_addr(s_addr), .ram_data(s_data),
    .ram_wr_en(s_wr_en), .frame_done(s_frame_done), .coord_err(s_coord_err), .busy(s_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared tri-state bus: only the acknowledged engine drives it, otherwise noise.
  always_comb begin
    engine_word = garbage;
    for (int k = 0; k < NP; k++)
      if (req_ack[k]) engine_word = eng_word[k];
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [26:0] mk_word(input int x, input int y, input int it);
    return {10'(x), 9'(y), 8'(it)};
  endfunction

  function automatic logic [26:0] rand_word();
    int x, y;
    x = $urandom_range(0, 639);
    y = $urandom_range(0, 479);
    if ($urandom_range(0, 15) == 0) begin
      if ($urandom_range(0, 1) == 1) x = $urandom_range(640, 1023);
      else                           y = $urandom_range(480, 511);
    end
    return mk_word(x, y, $urandom_range(0, 255));
  endfunction

  function automatic int rr_pick(input logic [NP-1:0] r, input int p);
    logic [3:0] j;
    for (int i = 0; i < NP; i++) begin
      j = 4'((p + i) % NP);
      if (r[j]) return (p + i) % NP;
    end
    return -1;
  endfunction

  task automatic expect_word(input logic [26:0] w);
    int x, y;
    x = int'(w[26:17]);
    y = int'(w[16:8]);
    if (x < 640 && y < 480) exp_q.push_back('{x + y * 640, int'(w[7:0]), cyc + 1});
    else                    exp_err = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    engine_req = '0;
    s_req = '0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1 check("pending_writes", exp_q.size(), 0);
  endtask

  task automatic serve(input int k, input logic [26:0] w);
    int t;
    @(posedge clk); #1;
    eng_word[k] = w;
    engine_req[k] = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!req_ack[k] && t < 40);
    check("serve_grant", req_ack[k], 1);
    t = 0;
    while (req_ack[k] && t < 10) begin @(posedge clk); #1; t++; end
    check("serve_release", req_ack[k], 0);
    engine_req[k] = 1'b0;
    expect_word(w);
  endtask

  // Each engine: request, hold until its grant ends, drop after 0-2 cycles, re-request after 0-4.
  task automatic run_engines(input int cycles);
    int est [NP];
    int cnt [NP];
    bit idle_all;
    idle_all = 1'b0;
    for (int k = 0; k < NP; k++) begin est[k] = 0; cnt[k] = 0; end
    for (int c = 0; c < cycles + 400; c++) begin
      @(posedge clk); #1;
      garbage = 27'($urandom);
      idle_all = 1'b1;
      for (int k = 0; k < NP; k++) begin
        case (est[k])
          0: if (c < cycles) begin
               if (cnt[k] == 0) begin
                 eng_word[k] = rand_word();
                 engine_req[k] = 1'b1;
                 est[k] = 1;
               end else cnt[k]--;
             end
          1: if (req_ack[k]) est[k] = 2;
          2: if (!req_ack[k]) begin
               expect_word(eng_word[k]);
               cnt[k] = $urandom_range(0, 2);
               est[k] = 3;
             end
          default: if (cnt[k] == 0) begin
               engine_req[k] = 1'b0;
               est[k] = 0;
               cnt[k] = $urandom_range(0, 4);
             end else cnt[k]--;
        endcase
        if (est[k] != 0) idle_all = 1'b0;
      end
      if (c >= cycles && idle_all) break;
    end
    check("engines_drained", idle_all, 1);
    settle();
  endtask

  // Monitor: round-robin grant model, grant length, and write scoreboard for the full-size instance.
  initial begin : main_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_ptr = 0; m_run = 0; m_bprev = 1'b0; m_rprev = '0;
      end else begin
        if (ram_wr_en) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %0d, expected no write (cycle %0d)", ram_addr, ram_data, cyc);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", ram_addr, e.addr);
            check("wr_data", ram_data, e.data);
            check("wr_cycle", cyc, e.due);
            check("frame_done", frame_done, 0);
          end
        end
        if (!m_bprev && m_rprev != '0) begin
          m_g = rr_pick(m_rprev, m_ptr);
          check("grant_select", req_ack, longint'(1) << m_g);
          m_gcur = m_g;
          m_reqg = engine_req[m_g[3:0]];
        end
        if (req_ack != '0) begin
          m_run++;
          check("ack_onehot", $countones(req_ack), 1);
        end else if (m_run != 0) begin
          check("ack_len", m_run, m_reqg ? 2 : 1);
          if (m_run == 2) m_ptr = (m_gcur + 1) % NP;
          m_run = 0;
        end
        m_bprev = busy;
        m_rprev = engine_req;
      end
    end
  end

  initial begin : small_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (s_frame_done) s_frames++;
        if (s_wr_en) begin
          s_writes++;
          if (s_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL s_unexpected_write: got addr %0d, expected no write (cycle %0d)", s_addr, cyc);
          end else begin
            e = s_q.pop_front();
            check("s_wr_addr", s_addr, e.addr);
            check("s_wr_data", s_data, e.data);
          end
          check("s_frame_done", s_frame_done, (s_writes % 32) == 0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    @(negedge clk);
    check("rst_req_ack", req_ack, 0);
    check("rst_wr_en", ram_wr_en, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", ram_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_coord_err", coord_err, 0);
    check("rst_busy", busy, 0);
    do_reset();

    serve(0, mk_word(5, 2, 8'h7F));
    settle();
    serve(1, mk_word(639, 479, 8'h33));
    settle();
    check("coord_err_clean", coord_err, 0);
    serve(2, mk_word(640, 0, 1));
    settle();
    check("coord_err_set", coord_err, exp_err);
    serve(4, mk_word(17, 300, 8'hA5));
    settle();
    check("coord_err_sticky", coord_err, 1);

    do_reset();
    #1 check("coord_err_after_reset", coord_err, 0);
    run_engines(1500);
    check("coord_err_random", coord_err, exp_err);

    // Engine 3 withdraws while in GRANT: no write, pointer untouched.
    @(posedge clk); #1;
    eng_word[3] = mk_word(10, 10, 10);
    engine_req[3] = 1'b1;
    @(posedge clk); #1;
    check("spur_ack", req_ack, 12'h008);
    engine_req[3] = 1'b0;
    @(posedge clk); #1;
    check("spur_ack_clr", req_ack, 0);
    check("spur_idle", busy, 0);
    settle();
    run_engines(200);

    // Reset lands while engine 5 is in CAPTURE.
    @(posedge clk); #1;
    eng_word[5] = mk_word(100, 100, 8'h55);
    engine_req[5] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("cap_ack", req_ack, 12'h020);
    reset = 1'b1;
    engine_req = '0;
    #1;
    check("arst_req_ack", req_ack, 0);
    check("arst_wr_en", ram_wr_en, 0);
    check("arst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_err = 1'b0;
    settle();
    run_engines(200);

    for (int n = 0; n < 65; n++) begin
      int x, y, it, k, t;
      x = $urandom_range(0, 7);
      y = $urandom_range(0, 3);
      it = $urandom_range(0, 255);
      k = n % 2;
      @(posedge clk); #1;
      s_word = mk_word(x, y, it);
      s_req[k] = 1'b1;
      t = 0;
      do begin @(posedge clk); #1; t++; end while (!s_ack[k] && t < 40);
      t = 0;
      while (s_ack[k] && t < 10) begin @(posedge clk); #1; t++; end
      s_req[k] = 1'b0;
      s_q.push_back('{x + y * 8, it, cyc + 1});
    end
    repeat (6) @(posedge clk);
    #1;
    check("s_pending", s_q.size(), 0);
    check("s_writes", s_writes, 65);
    check("s_frames", s_frames, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
